rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Eight-requester round-robin arbiter that hands a single shared resource, such as a memory port or register-file write port, to one requester at a time. It holds each grant until the owner releases it or a hold-timeout expires, then rotates priority. It sits between the requesting units and the shared port's select logic. It produces a 3-bit grant index and its one-hot decode.

## Interface
- `MAX_HOLD`, default 16: maximum cycles one grant may be held; legal range 2..256.
- `clk` in 1: the single clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 8: request vector; bit i is requester i, level-sensitive.
- `gnt` out 8: one-hot grant; all-zero when idle.
- `gnt_id` out 3: index of the current owner; 0 when idle.
- `gnt_valid` out 1: high while a grant is held.
- `timeout` out 1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- States: IDLE, BUSY. Reset state is IDLE.
- **IDLE**
  - The arbiter scans `req` starting at priority pointer `ptr`, upward with wrap 7→0.
  - The first set bit wins. It is latched into `gnt_id`, and the state goes to BUSY.
  - If `req` is 0, the state stays IDLE.
- **BUSY**
  - The owner keeps the grant while `req[gnt_id]` = 1.
  - Other requests are ignored.
  - The hold counter increments each BUSY cycle.
- **Release**
  - Trigger: `req[gnt_id]` = 0 in BUSY.
  - Next state is IDLE and `gnt` clears.
  - `ptr` is set to `gnt_id`+1 mod 8.
- **Timeout**
  - Trigger: the hold counter = `MAX_HOLD`-1 and `req[gnt_id]` is still 1.
  - Next state is IDLE, `gnt` clears, and `timeout` pulses for one cycle.
  - `ptr` is set to `gnt_id`+1 mod 8.
  - The revoked requester may keep `req` high. It re-enters arbitration at lowest priority.
- **Hold counter**
  - Width is clog2(`MAX_HOLD`). It clears on entry to BUSY.
  - It never wraps, because timeout fires first.
- **Pointer**
  - `ptr` is 3 bits and resets to 0, so requester 0 has highest priority after reset.
  - Wrap-around: a grant to 7 sets `ptr` to 0.
- **Outputs**
  - `gnt` is always the 3→8 decode of `gnt_id`, gated by `gnt_valid`.
  - `gnt_id`, `gnt_valid` and `timeout` are registered outputs.
- **Reset values:** `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, `ptr`=0, hold counter=0, state IDLE.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge N gives a grant visible after edge N (one cycle).
- **Release:** `req[gnt_id]` low at edge N drops `gnt` after edge N.
  - The next grant appears after edge N+1, leaving exactly one idle cycle between grants.
- **Timeout:**
  - The grant asserts after edge E.
  - It is held for exactly `MAX_HOLD` cycles.
  - `gnt` drops and `timeout` is high for the single cycle after edge E+`MAX_HOLD`.
- **Simultaneous release and timeout in the same cycle:** treated as a release, with no `timeout` pulse.
- **Requests arriving while BUSY:** wait. No request is lost while it is held high.
- **Reset asserted mid-grant:** all outputs clear immediately, asynchronously; `ptr` returns to 0.
- **Reset deassertion:** the first arbitration happens at the first edge with `rst_n` high.

## Structure
- **Shared package constants:**
  - `NUM_REQ`=8 and `REQ_IDX_W`=3.
  - State encoding IDLE=1'b0, BUSY=1'b1.
  - Default `MAX_HOLD`.
- **Sub-module:** the one-hot grant output is produced by a `decoder_3_8` instance from `gnt_id`, ANDed with `gnt_valid`.
- **Priority scan:** a rotate-by-`ptr`, find-first, un-rotate function, kept inside this block.

## Test plan
- **Reset, then single request:**
  - Stimulus: `req`=8'h04.
  - Response: after one edge, `gnt`=8'h04, `gnt_id`=2, `gnt_valid`=1.
  - Then drop `req`: `gnt`=0 after the next edge.
- **Round-robin fairness:**
  - Stimulus: `req`=8'hFF held; each owner drops its bit for one cycle after 3 BUSY cycles, then re-raises it.
  - Response: grant order 0,1,2,…,7,0, with one idle cycle between grants.
- **Wrap-around:**
  - Stimulus: grant 7 and release it, then `req`=8'h81.
  - Response: next `gnt_id`=0, and `ptr` ends at 1.
- **Timeout with `MAX_HOLD`=4:**
  - Stimulus: requester 5 holds `req` indefinitely, with `req`=8'h21.
  - Response: `gnt`=8'h20 for exactly 4 cycles, then `timeout`=1 for one cycle.
  - Then `gnt`=8'h01, because requester 0 outranks 5 after `ptr`=6 wraps.
- **Release on the final hold cycle:**
  - Stimulus: `req[gnt_id]` drops on cycle `MAX_HOLD`-1.
  - Response: `timeout` stays 0; normal release.
- **Asynchronous reset mid-grant:**
  - Stimulus: pull `rst_n` low between edges while `gnt`=8'h10.
  - Response: `gnt`, `gnt_id`, `gnt_valid` and `timeout` go to 0 without a clock edge.
  - After release of reset with `req`=8'h11: `gnt_id`=0.

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg
// Shared constants and types for the eight-requester round-robin arbiter.
//   NUM_REQ          : number of requesters
//   REQ_IDX_W        : width of a requester index
//   DEFAULT_MAX_HOLD : default grant hold limit in cycles
//   arb_state_e      : arbiter state encoding (IDLE / BUSY)
package rr_arbiter_8_pkg;

   localparam int unsigned NUM_REQ          = 8;
   localparam int unsigned REQ_IDX_W        = 3;
   localparam int unsigned DEFAULT_MAX_HOLD = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

endpackage : rr_arbiter_8_pkg

// File: rtl/rr_arbiter_8_decoder_3_8.sv
// decoder_3_8
// Plain 3-to-8 one-hot decoder used to build the grant vector.
//   sel : input  [2:0] index to decode
//   dec : output [7:0] one-hot decode of sel
module decoder_3_8 (
   input  logic [2:0] sel,
   output logic [7:0] dec
);

   // One-hot decode of the select index
   always_comb begin
      dec = 8'h00;
      case (sel)
         3'd0:    dec = 8'h01;
         3'd1:    dec = 8'h02;
         3'd2:    dec = 8'h04;
         3'd3:    dec = 8'h08;
         3'd4:    dec = 8'h10;
         3'd5:    dec = 8'h20;
         3'd6:    dec = 8'h40;
         3'd7:    dec = 8'h80;
         default: dec = 8'h00;
      endcase
   end

endmodule : decoder_3_8

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8
// Eight-requester round-robin arbiter for one shared resource. A grant is
// held until the owner drops its request or MAX_HOLD cycles elapse; either
// way priority then rotates to the requester just above the last owner.
//   MAX_HOLD  : parameter, maximum grant hold in cycles (2..256)
//   clk       : input, rising-edge clock
//   rst_n     : input, asynchronous active-low reset
//   req       : input  [7:0] level-sensitive request vector
//   gnt       : output [7:0] one-hot grant, zero when idle
//   gnt_id    : output [2:0] current owner index, zero when idle
//   gnt_valid : output, high while a grant is held
//   timeout   : output, one-cycle pulse when a grant is revoked by MAX_HOLD
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [REQ_IDX_W-1:0] gnt_id,
   output logic                 gnt_valid,
   output logic                 timeout
);

   localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0]    HOLD_ZERO = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [REQ_IDX_W-1:0] IDX_ZERO  = {REQ_IDX_W{1'b0}};
   localparam logic [REQ_IDX_W-1:0] IDX_ONE   = 3'd1;

   // Rotate requests so ptr sits at bit 0, take the lowest set bit, then
   // rotate the index back. Only meaningful when r is non-zero.
   function automatic logic [REQ_IDX_W-1:0] rr_pick(
      input logic [NUM_REQ-1:0]   r,
      input logic [REQ_IDX_W-1:0] p
   );
      logic [2*NUM_REQ-1:0]   dbl;
      logic [NUM_REQ-1:0]     rot;
      logic [REQ_IDX_W-1:0]   first;
      dbl   = {r, r};
      rot   = dbl[p +: NUM_REQ];
      first = IDX_ZERO;
      // Scanning downward lets the lowest set bit overwrite the others.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            first = k[REQ_IDX_W-1:0];
         end
      end
      return first + p;
   endfunction

   arb_state_e           state_q,     state_d;
   logic [REQ_IDX_W-1:0] gnt_id_q,    gnt_id_d;
   logic                 gnt_valid_q, gnt_valid_d;
   logic                 timeout_q,   timeout_d;
   logic [REQ_IDX_W-1:0] ptr_q,       ptr_d;
   logic [HOLD_W-1:0]    hold_q,      hold_d;
   logic [NUM_REQ-1:0]   gnt_dec_s;

   // Next-state and registered-output computation for the IDLE/BUSY machine
   always_comb begin
      state_d     = state_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d     = BUSY;
               gnt_id_d    = rr_pick(req, ptr_q);
               gnt_valid_d = 1'b1;
               hold_d      = HOLD_ZERO;
            end else begin
               state_d     = IDLE;
               gnt_id_d    = IDX_ZERO;
               gnt_valid_d = 1'b0;
            end
         end
         BUSY: begin
            // Release wins over timeout when both land on the same edge.
            if (!req[gnt_id_q]) begin
               state_d     = IDLE;
               gnt_id_d    = IDX_ZERO;
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_id_q + IDX_ONE;
               hold_d      = HOLD_ZERO;
            end else if (hold_q == HOLD_LAST) begin
               state_d     = IDLE;
               gnt_id_d    = IDX_ZERO;
               gnt_valid_d = 1'b0;
               timeout_d   = 1'b1;
               ptr_d       = gnt_id_q + IDX_ONE;
               hold_d      = HOLD_ZERO;
            end else begin
               hold_d      = hold_q + HOLD_ONE;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_id_d    = IDX_ZERO;
            gnt_valid_d = 1'b0;
            ptr_d       = IDX_ZERO;
            hold_d      = HOLD_ZERO;
         end
      endcase
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_id_q    <= IDX_ZERO;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         ptr_q       <= IDX_ZERO;
         hold_q      <= HOLD_ZERO;
      end else begin
         state_q     <= state_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
      end
   end

   decoder_3_8 u_gnt_dec (
      .sel (gnt_id_q),
      .dec (gnt_dec_s)
   );

   assign gnt       = gnt_dec_s & {NUM_REQ{gnt_valid_q}};
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule : rr_arbiter_8

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8
// Directed and randomized checks of rr_arbiter_8 (MAX_HOLD = 4) against a
// cycle-level reference model that tracks owner, priority pointer and how
// many cycles the current grant has been visible.
module tb_rr_arbiter_8;

   localparam int unsigned MAX_HOLD = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req   = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int n_asserts = 0;
   int n_fail    = 0;

   // reference model state
   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_to    = 1'b0;

   rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;
   endtask

   // One rising edge of the arbiter as described by its rules.
   task automatic model_edge(input logic [7:0] r);
      bit found;
      m_to = 1'b0;
      if (m_busy) begin
         if (!r[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 8;
         end else if (m_held == MAX_HOLD) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
            m_ptr  = (m_owner + 1) % 8;
         end else begin
            m_held++;
         end
      end else if (r != 8'h00) begin
         found = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (!found && r[(m_ptr + k) % 8]) begin
               found   = 1'b1;
               m_owner = (m_ptr + k) % 8;
            end
         end
         m_busy = 1'b1;
         m_held = 1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] one;
      logic [7:0] exp_gnt;
      one     = 8'h01;
      exp_gnt = m_busy ? (one << m_owner) : 8'h00;
      check({tag, ".gnt"},       gnt,                exp_gnt);
      check({tag, ".gnt_id"},    {5'b00000, gnt_id}, m_busy ? 8'(m_owner) : 8'h00);
      check({tag, ".gnt_valid"}, {7'b0, gnt_valid},  {7'b0, m_busy});
      check({tag, ".timeout"},   {7'b0, timeout},    {7'b0, m_to});
   endtask

   task automatic step(input logic [7:0] r, input string tag);
      req = r;
      @(posedge clk);
      model_edge(r);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      model_reset();
      #1;
      check_all("reset");
      @(posedge clk);
      #1;
      check_all("reset_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      int         seen;
      logic       prev_v;
      logic [7:0] r;

      do_reset();

      // single request, then release
      step(8'h04, "single");
      check("single_gnt", gnt, 8'h04);
      check("single_id", {5'b00000, gnt_id}, 8'h02);
      step(8'h00, "single_rel");
      check("single_rel_gnt", gnt, 8'h00);

      // fairness from reset: owners drop their bit after 3 visible cycles
      do_reset();
      seen   = 0;
      prev_v = gnt_valid;
      for (int s = 0; s < 120 && seen < 9; s++) begin
         r = 8'hFF;
         if (m_busy && m_held == 3) r[m_owner] = 1'b0;
         step(r, "fair");
         if (gnt_valid && !prev_v) begin
            check("fair_order", {5'b00000, gnt_id}, 8'(seen % 8));
            seen++;
         end
         prev_v = gnt_valid;
      end
      check("fair_grants_seen", 8'(seen), 8'd9);
      step(8'h00, "fair_rel");

      // wrap-around: grant 7, release, then 0 wins; pointer then sits at 1
      step(8'h80, "wrap_g7");
      check("wrap_g7_id", {5'b00000, gnt_id}, 8'h07);
      step(8'h00, "wrap_rel7");
      step(8'h81, "wrap_g0");
      check("wrap_g0_id", {5'b00000, gnt_id}, 8'h00);
      step(8'h80, "wrap_rel0");
      step(8'h81, "wrap_ptr1");
      check("wrap_ptr1_id", {5'b00000, gnt_id}, 8'h07);
      step(8'h00, "wrap_rel");

      // move pointer to 5, then requester 5 holds until timeout
      step(8'h10, "to_g4");
      step(8'h00, "to_rel4");
      for (int c = 0; c < 4; c++) begin
         step(8'h21, "to_hold");
         check("to_hold_gnt", gnt, 8'h20);
      end
      step(8'h21, "to_pulse");
      check("to_pulse_timeout", {7'b0, timeout}, 8'h01);
      check("to_pulse_gnt", gnt, 8'h00);
      step(8'h21, "to_next");
      check("to_next_gnt", gnt, 8'h01);
      check("to_next_timeout", {7'b0, timeout}, 8'h00);

      // owner 0 releases on the very edge a timeout would fire
      step(8'h21, "last_h2");
      step(8'h21, "last_h3");
      step(8'h21, "last_h4");
      step(8'h20, "last_rel");
      check("last_rel_timeout", {7'b0, timeout}, 8'h00);
      check("last_rel_gnt", gnt, 8'h00);
      step(8'h20, "last_next");
      check("last_next_gnt", gnt, 8'h20);
      step(8'h00, "last_done");

      // randomized traffic, owner usually keeps its request up
      for (int s = 0; s < 300; s++) begin
         r = 8'($urandom);
         if (m_busy && $urandom_range(3, 0) != 0) r[m_owner] = 1'b1;
         step(r, "rand");
      end

      // asynchronous reset while requester 4 owns the resource
      step(8'h00, "ar_idle0");
      step(8'h00, "ar_idle1");
      step(8'h10, "ar_grant");
      check("ar_grant_gnt", gnt, 8'h10);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("ar_async");
      check("ar_async_gnt", gnt, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h11, "ar_after");
      check("ar_after_id", {5'b00000, gnt_id}, 8'h00);
      check("ar_after_gnt", gnt, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_rr_arbiter_8
